// File: rtl/arcade_input_cond.sv
// Per-player joystick conditioner: registered input, per-bit debounce, SOCD, autofire, coin stretch + credits.
// Latency 2+DEBOUNCE_CYC for dirs/buttons/start; no backpressure, inputs are sampled every cycle.
module arcade_input_cond #(
    parameter int NUM_PLAYERS  = 2,
    parameter int NUM_BTN      = 2,
    parameter int DEBOUNCE_CYC = 16,
    parameter int COIN_LEN     = 36864,
    parameter int COIN_GAP     = 18432,
    parameter int AUTOFIRE_DIV = 300000,
    parameter int SOCD_NEUTRAL = 1,
    parameter int MERGE        = 0
) (
    input  logic                           clk_sys,
    input  logic                           reset,
    input  logic [NUM_PLAYERS*16-1:0]      joy_in,
    input  logic [NUM_PLAYERS*NUM_BTN-1:0] autofire_en,
    input  logic                           pause,
    output logic [NUM_PLAYERS*4-1:0]       dir_out,
    output logic [NUM_PLAYERS*NUM_BTN-1:0] btn_out,
    output logic [NUM_PLAYERS-1:0]         start_out,
    output logic [NUM_PLAYERS-1:0]         coin_out,
    output logic [7:0]                     coin_cnt
);
    localparam int NB       = 6 + NUM_BTN;
    localparam int AFW      = $clog2(AUTOFIRE_DIV > 2 ? AUTOFIRE_DIV : 2);
    localparam int CMAX     = COIN_LEN > COIN_GAP ? COIN_LEN : COIN_GAP;
    localparam int CW       = $clog2(CMAX > 2 ? CMAX : 2);
    localparam logic [AFW-1:0] AF_LAST  = AFW'(AUTOFIRE_DIV - 1);
    localparam logic [CW-1:0]  LEN_LAST = CW'(COIN_LEN - 1);
    localparam logic [CW-1:0]  GAP_LAST = CW'(COIN_GAP - 1);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_PULSE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_GUARD = 2'd3;

    logic [NUM_PLAYERS*NB-1:0] raw_d, raw_q, deb;
    logic                      unused_joy;

    always_comb begin
        raw_d      = '0;
        unused_joy = 1'b0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            raw_d[p*NB +: NB] = joy_in[p*16 +: NB];
            for (int b = NB; b < 16; b++) unused_joy = unused_joy ^ joy_in[p*16+b];
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) raw_q <= '0;
        else       raw_q <= raw_d;
    end

    generate
        if (DEBOUNCE_CYC == 0) begin : g_nodb
            assign deb = raw_q;
        end else begin : g_db
            localparam int DBW = $clog2(DEBOUNCE_CYC > 2 ? DEBOUNCE_CYC : 2);
            localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYC - 1);
            for (genvar i = 0; i < NUM_PLAYERS*NB; i++) begin : g_bit
                logic           deb_q;
                logic [DBW-1:0] cnt_q;
                always_ff @(posedge clk_sys) begin
                    if (reset) begin
                        deb_q <= 1'b0;
                        cnt_q <= '0;
                    end else if (raw_q[i] == deb_q) begin
                        cnt_q <= '0;
                    end else if (cnt_q == DB_LAST) begin
                        deb_q <= raw_q[i];
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                assign deb[i] = deb_q;
            end
        end
    endgenerate

    // Shared autofire phase; buttons are not resynchronised on press.
    logic [AFW-1:0] af_cnt_q, af_cnt_d;
    logic           phase_q, phase_d;

    always_comb begin
        af_cnt_d = af_cnt_q;
        phase_d  = phase_q;
        if (!pause) begin
            if (af_cnt_q == AF_LAST) begin
                af_cnt_d = '0;
                phase_d  = ~phase_q;
            end else begin
                af_cnt_d = af_cnt_q + 1'b1;
            end
        end
    end

    logic [NUM_PLAYERS*4-1:0]       dir_c, dir_d, dir_q;
    logic [NUM_PLAYERS*NUM_BTN-1:0] btn_c, btn_d, btn_q;
    logic [NUM_PLAYERS-1:0]         start_d, start_q;

    always_comb begin
        dir_c   = '0;
        btn_c   = '0;
        start_d = '0;
        for (int p = 0; p < NUM_PLAYERS; p++) begin
            dir_c[p*4 +: 4] = deb[p*NB +: 4];
            if (SOCD_NEUTRAL != 0) begin
                if (dir_c[p*4+3] && dir_c[p*4+2]) dir_c[p*4+2 +: 2] = 2'b00;
                if (dir_c[p*4+1] && dir_c[p*4])   dir_c[p*4 +: 2]   = 2'b00;
            end
            for (int b = 0; b < NUM_BTN; b++)
                btn_c[p*NUM_BTN+b] = deb[p*NB+4+b] & (autofire_en[p*NUM_BTN+b] ? phase_q : 1'b1);
            start_d[p] = deb[p*NB+4+NUM_BTN];
        end
        if (MERGE != 0) begin
            dir_d = '0;
            btn_d = '0;
            for (int p = 0; p < NUM_PLAYERS; p++) begin
                dir_d[3:0]         = dir_d[3:0] | dir_c[p*4 +: 4];
                btn_d[NUM_BTN-1:0] = btn_d[NUM_BTN-1:0] | btn_c[p*NUM_BTN +: NUM_BTN];
            end
        end else begin
            dir_d = dir_c;
            btn_d = btn_c;
        end
    end

    logic [NUM_PLAYERS-1:0] accept;

    generate
        for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
            logic [1:0]    state_q, state_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          out_q, out_d;
            logic          coin_deb;
            assign coin_deb = deb[p*NB+5+NUM_BTN];

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                out_d   = out_q;
                case (state_q)
                    S_IDLE: if (coin_deb) begin
                        state_d = S_PULSE;
                        cnt_d   = '0;
                        out_d   = 1'b1;
                    end
                    S_PULSE: if (cnt_q == LEN_LAST) begin
                        state_d = S_WAIT;
                        out_d   = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    S_WAIT: if (!coin_deb) begin
                        state_d = S_GUARD;
                        cnt_d   = '0;
                    end
                    default: if (cnt_q == GAP_LAST) state_d = S_IDLE;
                             else                   cnt_d   = cnt_q + 1'b1;
                endcase
            end

            always_ff @(posedge clk_sys) begin
                if (reset) begin
                    state_q <= S_IDLE;
                    cnt_q   <= '0;
                    out_q   <= 1'b0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                    out_q   <= out_d;
                end
            end

            assign accept[p]   = (state_q == S_IDLE) && coin_deb;
            assign coin_out[p] = out_q;
        end
    endgenerate

    logic [7:0] coin_cnt_q, coin_cnt_d;

    always_comb begin
        coin_cnt_d = coin_cnt_q;
        for (int p = 0; p < NUM_PLAYERS; p++) coin_cnt_d = coin_cnt_d + {7'b0, accept[p]};
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            af_cnt_q   <= '0;
            phase_q    <= 1'b0;
            dir_q      <= '0;
            btn_q      <= '0;
            start_q    <= '0;
            coin_cnt_q <= '0;
        end else begin
            af_cnt_q   <= af_cnt_d;
            phase_q    <= phase_d;
            dir_q      <= dir_d;
            btn_q      <= btn_d;
            start_q    <= start_d;
            coin_cnt_q <= coin_cnt_d;
        end
    end

    assign dir_out   = dir_q;
    assign btn_out   = btn_q;
    assign start_out = start_q;
    assign coin_cnt  = coin_cnt_q;
endmodule

// File: doc/arcade_input_cond.md
Name: arcade_input_cond

Overview:
- Parametrised conditioner for the HPS joystick words. It sits between hps_io and the arcade core.
- Replaces the flat combinational joystick OR-mapping with per-player channels.
- Adds per-bit debounce, opposing-direction (SOCD) cleaning, per-button autofire, and a coin pulse-stretch FSM with a credit counter.
- Optional MERGE mode reproduces the current behaviour, where all players are OR'd onto player 0.

Parameters:
- NUM_PLAYERS, 2, number of joystick channels (1..4).
- NUM_BTN, 2, action buttons per player (1..10).
- DEBOUNCE_CYC, 16, consecutive stable clk_sys cycles needed to change a debounced bit; 0 = no debounce.
- COIN_LEN, 36864, clk_sys cycles coin_out is held high per accepted coin.
- COIN_GAP, 18432, clk_sys cycles coin_out is forced low before the next coin is accepted.
- AUTOFIRE_DIV, 300000, clk_sys cycles per autofire phase toggle.
- SOCD_NEUTRAL, 1, when 1, opposing directions both pressed resolve to neither.
- MERGE, 0, when 1, dirs/buttons of all players are OR'd onto player 0.

Ports:
- clk_sys  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- joy_in  in  NUM_PLAYERS*16  raw joystick words, player p at [16p+:16].
  - Bit map: 0 right, 1 left, 2 down, 3 up.
  - [4+:NUM_BTN] buttons.
  - 4+NUM_BTN start.
  - 5+NUM_BTN coin.
- autofire_en  in  NUM_PLAYERS*NUM_BTN  per-button autofire enable (static, from status bits).
- pause  in  1  freezes the autofire phase counter.
- dir_out  out  NUM_PLAYERS*4  conditioned {up,down,left,right} per player.
- btn_out  out  NUM_PLAYERS*NUM_BTN  conditioned buttons.
- start_out  out  NUM_PLAYERS  debounced start.
- coin_out  out  NUM_PLAYERS  stretched coin pulse.
- coin_cnt  out  8  total accepted coins, wraps 255->0.

Behaviour:
- Reset: all outputs 0, debounced state 0, all counters 0, autofire phase 0, coin FSMs in IDLE. Reset overrides everything in the same cycle, including mid-pulse.
- Input stage: joy_in is registered once (1 cycle).
- Debounce, per used bit:
  - Counter runs while the registered raw value differs from the debounced value.
  - Counter clears on any cycle where they match.
  - When the counter reaches DEBOUNCE_CYC-1 with a mismatch still present, the debounced value takes the raw value and the counter clears.
  - Debounced latency = 1 + DEBOUNCE_CYC cycles. With DEBOUNCE_CYC=0 the debounced value equals the registered value (1 cycle).
- SOCD, applied to debounced dirs when SOCD_NEUTRAL=1: up&down -> both 0; left&right -> both 0. Other combinations pass unchanged.
- Autofire:
  - One shared counter 0..AUTOFIRE_DIV-1 increments each cycle unless pause=1.
  - At the terminal count it wraps to 0 and the phase toggles.
  - btn = debounced & (autofire_en ? phase : 1).
  - No phase resync on press; worst-case first-shot delay is AUTOFIRE_DIV cycles.
- Output register: dir_out/btn_out/start_out are registered after SOCD/autofire. Total latency = 2 + DEBOUNCE_CYC.
- MERGE=1:
  - Player 0 dir_out/btn_out = OR over players, applied after each player's own SOCD and autofire.
  - dir_out/btn_out of players 1..N-1 are 0.
  - start_out and coin_out stay per-player.
- Coin FSM, one per player, driven by debounced coin:
  - IDLE: on debounced coin=1, go to PULSE, load counter, coin_out<=1, and credit the player.
  - PULSE: count COIN_LEN cycles with coin_out=1, then go to WAIT_REL with coin_out<=0.
  - WAIT_REL: wait for debounced coin=0, then go to GUARD.
  - GUARD: count COIN_GAP cycles with coin_out=0, then go to IDLE.
  - Coin activity outside IDLE is ignored, so a held coin yields exactly one credit.
  - coin_out rises 1 cycle after the debounced coin rises and stays high exactly COIN_LEN cycles.
- coin_cnt:
  - Adds the number of FSMs taking IDLE->PULSE in that cycle; simultaneous coins from k players add k.
  - Modulo 256 arithmetic.
- Counter widths: $clog2(max(param,2)) bits each; no overflow beyond the terminal count.

Test Plan:
- Reset, then joy_in=0 for 100 cycles -> all outputs 0, coin_cnt=0.
- DEBOUNCE_CYC=16, player 0 bit4 high for 10 cycles, low, then high steady:
  - Glitch produces no btn_out.
  - Steady press gives btn_out[0]=1 exactly 18 cycles after the steady rise.
- Player 0 joy_in bits 2 and 3 both high (SOCD_NEUTRAL=1) -> dir_out[3:0]=0. With only bit 3 high -> dir_out[3]=1.
- AUTOFIRE_DIV=8, autofire_en[0]=1, button held:
  - btn_out[0] toggles every 8 cycles.
  - pause=1 freezes its level.
  - autofire_en=0 gives constant 1.
- COIN_LEN=20, COIN_GAP=10, coin held 100 cycles: single 20-cycle coin_out pulse, coin_cnt=1.
- Second press during GUARD is ignored. Both players' coins rising the same cycle -> coin_cnt +2.
- coin_cnt at 255 plus one coin -> 0.
- MERGE=1, player 1 right pressed -> dir_out[0]=1, dir_out[7:4]=0.
- Reset asserted mid-PULSE -> coin_out=0 next cycle, FSM IDLE, coin_cnt=0.
